// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters (CPU port A, I/O port B), the arbiter
// and the single-ported data memory.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds
    // them stable until x_ack; x_ack is a one-cycle pulse carrying x_err and
    // x_rdata, and the arbiter samples request fields only when it is idle.
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_err, a_rdata,
        output b_ack, b_err, b_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_err, a_rdata,
        input  b_ack, b_err, b_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of a negedge-sampling data memory.
// Each access takes IDLE -> ACCESS -> RESP; ack pulses two cycles after the request edge.
module data_memory_arbiter #(
    parameter int DEPTH  = 31,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    data_memory_arbiter_if.slave       bus,
    output logic                       busy,
    output logic [1:0]                 dbg_state_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              gnt_b_q, gnt_b_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              a_ack_q, a_ack_d;
    logic              a_err_q, a_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic              b_ack_q, b_ack_d;
    logic              b_err_q, b_err_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              pick_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    // On a tie the port that did not win last time is chosen.
    assign pick_b    = bus.b_req & (~bus.a_req | ~last_b_q);
    assign sel_we    = pick_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        gnt_b_d     = gnt_b_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        a_ack_d     = 1'b0;
        a_err_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_ack_d     = 1'b0;
        b_err_d     = 1'b0;
        b_rdata_d   = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    state_d     = ACCESS;
                    gnt_b_d     = pick_b;
                    last_b_d    = pick_b;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we & ~sel_oor;
                    mem_re_d    = ~sel_we & ~sel_oor;
                end
            end
            ACCESS: begin
                // mem_rdata was produced at the negedge inside this ACCESS cycle.
                state_d = RESP;
                if (gnt_b_q) begin
                    b_ack_d = 1'b1;
                    b_err_d = oor_q;
                    if (oor_q)      b_rdata_d = '0;
                    else if (!we_q) b_rdata_d = bus.mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    a_err_d = oor_q;
                    if (oor_q)      a_rdata_d = '0;
                    else if (!we_q) a_rdata_d = bus.mem_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            gnt_b_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            a_ack_q     <= 1'b0;
            a_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_ack_q     <= 1'b0;
            b_err_q     <= 1'b0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            gnt_b_q     <= gnt_b_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            a_ack_q     <= a_ack_d;
            a_err_q     <= a_err_d;
            a_rdata_q   <= a_rdata_d;
            b_ack_q     <= b_ack_d;
            b_err_q     <= b_err_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.a_err     = a_err_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.b_err     = b_err_q;
    assign bus.b_rdata   = b_rdata_q;

    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a negedge-sampling memory model.
module tb_data_memory_arbiter;

  localparam int DEPTH  = 31;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;

  logic             clock;
  logic             reset;
  logic             busy;
  logic [1:0]       dbg_state;
  int               n_vec;
  int               n_err;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_memory_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: samples controls on the falling edge
  always @(negedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata = mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_vec++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b00) begin n_err++; $display("FAIL reset_mem_ctl got %b exp 00", {bus.mem_we, bus.mem_re}); end
    n_vec++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
    n_vec++; if ({bus.a_ack, bus.a_err, bus.b_ack, bus.b_err} !== 4'b0000) begin n_err++; $display("FAIL reset_ack_err got %b exp 0000", {bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}); end
    n_vec++; if (bus.a_rdata !== '0 || bus.b_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got %h/%h exp 0/0", bus.a_rdata, bus.b_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_write_read_a();
    drive_a(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    tick();
    n_vec++; if (busy !== 1'b1 || dbg_state !== S_ACCESS) begin n_err++; $display("FAIL wr_access got busy=%0b st=%0d exp 1/%0d", busy, dbg_state, S_ACCESS); end
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b10) begin n_err++; $display("FAIL wr_mem_ctl got %b exp 10", {bus.mem_we, bus.mem_re}); end
    n_vec++; if (bus.mem_addr !== 10'd5 || bus.mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_mem_bus got %h/%h exp 005/deadbeef", bus.mem_addr, bus.mem_wdata); end
    n_vec++; if (bus.a_ack !== 1'b0) begin n_err++; $display("FAIL wr_early_ack got %0b exp 0", bus.a_ack); end
    tick();
    n_vec++; if ({bus.a_ack, bus.a_err, bus.b_ack} !== 3'b100) begin n_err++; $display("FAIL wr_ack got %b exp 100", {bus.a_ack, bus.a_err, bus.b_ack}); end
    n_vec++; if (bus.a_rdata !== '0) begin n_err++; $display("FAIL wr_rdata_hold got %h exp 0", bus.a_rdata); end
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b00) begin n_err++; $display("FAIL wr_mem_ctl_resp got %b exp 00", {bus.mem_we, bus.mem_re}); end
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    n_vec++; if (bus.a_ack !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse got ack=%0b busy=%0b exp 0/0", bus.a_ack, busy); end
    n_vec++; if (bus.mem_addr !== 10'd5) begin n_err++; $display("FAIL wr_addr_hold got %h exp 005", bus.mem_addr); end
    drive_a(1'b1, 1'b0, 10'd5, 32'h0);
    tick();
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b01) begin n_err++; $display("FAIL rd_mem_ctl got %b exp 01", {bus.mem_we, bus.mem_re}); end
    tick();
    n_vec++; if ({bus.a_ack, bus.a_err} !== 2'b10) begin n_err++; $display("FAIL rd_ack got %b exp 10", {bus.a_ack, bus.a_err}); end
    n_vec++; if (bus.a_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got %h exp deadbeef", bus.a_rdata); end
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    n_vec++; if (bus.a_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data_hold got %h exp deadbeef", bus.a_rdata); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    logic exp_b;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_a(1'b1, 1'b1, 10'd1, 32'h0000_0011);
    drive_b(1'b1, 1'b1, 10'd2, 32'h0000_0022);
    // acks expected after edges 2,5,8,11 in order A,B,A,B
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp_a = (j == 2) || (j == 8);
      exp_b = (j == 5) || (j == 11);
      n_vec++;
      if (bus.a_ack !== exp_a || bus.b_ack !== exp_b) begin
        n_err++;
        $display("FAIL rr_edge%0d got a=%0b b=%0b exp a=%0b b=%0b", j, bus.a_ack, bus.b_ack, exp_a, exp_b);
      end
    end
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    drive_b(1'b0, 1'b0, 10'd0, 32'h0);
    n_vec++; if (mem[1] !== 32'h11 || mem[2] !== 32'h22) begin n_err++; $display("FAIL rr_mem got %h/%h exp 11/22", mem[1], mem[2]); end
    tick();
  endtask

  task automatic test_out_of_range_b();
    drive_b(1'b1, 1'b1, 10'd31, 32'hBAD0_BAD0);
    tick();
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL oor_mem_ctl got %b busy=%0b exp 00 busy=1", {bus.mem_we, bus.mem_re}, busy); end
    tick();
    n_vec++; if ({bus.b_ack, bus.b_err, bus.a_ack, bus.a_err} !== 4'b1100) begin n_err++; $display("FAIL oor_ack_err got %b exp 1100", {bus.b_ack, bus.b_err, bus.a_ack, bus.a_err}); end
    n_vec++; if (bus.b_rdata !== '0) begin n_err++; $display("FAIL oor_rdata got %h exp 0", bus.b_rdata); end
    drive_b(1'b1, 1'b0, 10'd30, 32'h0);
    tick();
    n_vec++; if ({bus.b_ack, bus.b_err} !== 2'b00) begin n_err++; $display("FAIL oor_err_clear got %b exp 00", {bus.b_ack, bus.b_err}); end
    tick();
    n_vec++; if ({bus.mem_we, bus.mem_re} !== 2'b01 || bus.mem_addr !== 10'd30) begin n_err++; $display("FAIL last_mem_ctl got %b addr %h exp 01 01e", {bus.mem_we, bus.mem_re}, bus.mem_addr); end
    drive_b(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    n_vec++; if ({bus.b_ack, bus.b_err} !== 2'b10) begin n_err++; $display("FAIL last_ack got %b exp 10", {bus.b_ack, bus.b_err}); end
    n_vec++; if (bus.b_rdata !== 32'hA000_001E) begin n_err++; $display("FAIL last_rdata got %h exp a000001e", bus.b_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_a(1'b1, 1'b0, 10'd7, 32'h0);
    tick();
    n_vec++; if (bus.mem_re !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_access got re=%0b busy=%0b exp 1/1", bus.mem_re, busy); end
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0 || bus.a_ack !== 1'b0 || bus.a_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_out got busy=%0b ack=%0b err=%0b exp 0/0/0", busy, bus.a_ack, bus.a_err); end
    n_vec++; if (bus.a_rdata !== '0 || bus.mem_addr !== '0 || bus.mem_re !== 1'b0) begin n_err++; $display("FAIL rst_mid_regs got rdata=%h addr=%h re=%0b exp 0/0/0", bus.a_rdata, bus.mem_addr, bus.mem_re); end
    tick();
    n_vec++; if (bus.a_ack !== 1'b0) begin n_err++; $display("FAIL rst_mid_late_ack got %0b exp 0", bus.a_ack); end
    drive_a(1'b1, 1'b0, 10'd7, 32'h0);
    tick();
    tick();
    n_vec++; if (bus.a_ack !== 1'b1 || bus.a_rdata !== 32'hA000_0007) begin n_err++; $display("FAIL rst_mid_next got ack=%0b rdata=%h exp 1/a0000007", bus.a_ack, bus.a_rdata); end
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
  endtask

  task automatic test_drop_req();
    int acks;
    drive_a(1'b1, 1'b1, 10'd9, 32'h0000_0099);
    tick();
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    n_vec++; if (bus.a_ack !== 1'b1) begin n_err++; $display("FAIL drop_ack got %0b exp 1", bus.a_ack); end
    tick();
    n_vec++; if (bus.a_ack !== 1'b0) begin n_err++; $display("FAIL drop_ack_pulse got %0b exp 0", bus.a_ack); end
    drive_a(1'b1, 1'b0, 10'd9, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    acks = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (bus.a_ack === 1'b1) acks++;
    end
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL single_edge_acks got %0d exp 1", acks); end
    n_vec++; if (bus.a_rdata !== 32'h0000_0099 || busy !== 1'b0) begin n_err++; $display("FAIL single_edge_rdata got %h busy=%0b exp 00000099/0", bus.a_rdata, busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA000_0000 + i;
    bus.mem_rdata = '0;
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 10'd0, 32'h0);
    drive_b(1'b0, 1'b0, 10'd0, 32'h0);
    test_reset();
    test_write_read_a();
    test_round_robin();
    test_out_of_range_b();
    test_reset_mid_access();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 31, number of implemented data-memory words (valid addresses 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 10, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports a_req/b_req  in  1  access request, port A (CPU) / port B (I/O).
REQ-007 SHALL have ports a_we/b_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr/b_addr  in  ADDR_W  word address.
REQ-009 SHALL have ports a_wdata/b_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports a_ack/b_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports a_err/b_err  out  1  out-of-range flag, valid with ack.
REQ-012 SHALL have ports a_rdata/b_rdata  out  DATA_W  read data, valid with ack, held until next ack on that port.
REQ-013 SHALL have ports mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_we  out  1, mem_re  out  1  drive the data memory (memory samples on negedge).
REQ-014 SHALL have port mem_rdata  in  DATA_W  memory read output.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req high at posedge; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 SHALL, in IDLE with one req high, grant that port; with both high, grant the port not granted last (round-robin).
REQ-018 SHALL reset the last-grant register to B, so A wins the first tie after reset.
REQ-019 SHALL, on the IDLE->ACCESS edge, register the granted port's addr, wdata and we into mem_addr/mem_wdata and an internal we copy.
REQ-020 SHALL assert exactly one of mem_we (we=1) or mem_re (we=0) for exactly the ACCESS cycle, registered, glitch-free.
REQ-021 SHALL assert neither mem_we nor mem_re when the granted addr >= DEPTH; the access completes with err=1.
REQ-022 SHALL, on the ACCESS->RESP edge, load granted port's rdata from mem_rdata for an in-range read, 0 for an error; rdata unchanged for an in-range write.
REQ-023 SHALL assert granted port's ack (and err if out of range) only during RESP; the other port's ack/err stay 0.
REQ-024 SHALL give request-to-ack latency of 2 cycles: req sampled at edge k, ACCESS cycle k..k+1, ack high cycle k+1..k+2.
REQ-025 SHALL require requester to hold req/we/addr/wdata stable until ack; fields are sampled only at the IDLE edge.
REQ-026 SHALL treat a req still high at the edge after RESP as a new request (back-to-back throughput: one access per 3 cycles).
REQ-027 SHALL ignore req changes while busy; a port dropping req during ACCESS still receives its ack.
REQ-028 SHALL never grant both ports in the same access; mem_addr/mem_wdata hold their value outside ACCESS.

Reset
REQ-029 SHALL, on reset, set state IDLE, last grant B, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, all ack/err=0, a_rdata=b_rdata=0, busy=0.
REQ-030 SHALL, on reset during ACCESS or RESP, abandon the access with no ack; a memory write already sampled at the preceding negedge stands.
REQ-031 SHALL give reset priority over every request at the same edge.

Verification
REQ-032 SHALL pass: reset, a_req write addr 5 data 0xDEADBEEF, then a_req read addr 5 -> a_ack 2 cycles after each req edge, a_rdata=0xDEADBEEF, a_err=0.
REQ-033 SHALL pass: a_req and b_req held high continuously after reset -> grants A,B,A,B; acks alternate every 3 cycles, never simultaneous.
REQ-034 SHALL pass: b_req write addr 31 (DEPTH=31) -> mem_we never asserted, b_ack=1 with b_err=1; then read addr 30 -> b_err=0.
REQ-035 SHALL pass: reset asserted during ACCESS of a read -> no ack, busy=0 and all outputs at reset values next cycle, next request served normally.
REQ-036 SHALL pass: a_req dropped during ACCESS -> a_ack still pulses one cycle; a_req high for one IDLE edge only -> exactly one access.
